// File: rtl/ddr2_idelay_pkg.sv
// Shared state encoding and default constants for the IDELAYCTRL reset/lock sequencer.
package ddr2_idelay_pkg;

   typedef enum logic [1:0] {
      RST_HOLD = 2'd0,
      WAIT_RDY = 2'd1,
      LOCKED   = 2'd2,
      FAILED   = 2'd3
   } ctrl_state_e;

   localparam int unsigned DEF_RST_CYCLES   = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT = 4096;
   localparam int unsigned DEF_MAX_RETRY    = 3;
   localparam int unsigned DEF_SYNC_STAGES  = 2;

   // Programmed RDY delay value meaning "this instance never locks".
   localparam logic [7:0] MODEL_NEVER_RDY = 8'hFF;

endpackage

// File: rtl/ddr2_idelayctrl_cell.sv
// One IDELAYCTRL site carrying the IODELAY_GROUP attribute. The body is a
// behavioural stand-in: RDY rises model_dly cycles after RST falls, and is
// forced low for every cycle model_drop is sampled high.
module ddr2_idelayctrl_cell
   import ddr2_idelay_pkg::*;
#(
   parameter string IODELAY_GRP = "IODELAY_MIG"
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       rst,
   input  logic [7:0] model_dly,
   input  logic       model_drop,
   output logic       rdy
);

   // An instance outside any delay group can never be calibrated.
   localparam bit HAS_GROUP = (IODELAY_GRP != "");

   logic [7:0] low_cnt_q, low_cnt_d;
   (* IODELAY_GROUP = IODELAY_GRP *)
   logic       rdy_q;
   logic       rdy_d;

   // Count cycles since RST fell (saturating) and derive RDY from the programmed delay.
   always_comb begin
      low_cnt_d = low_cnt_q;
      rdy_d     = 1'b0;
      if (rst) begin
         low_cnt_d = '0;
      end else begin
         if (low_cnt_q != '1) low_cnt_d = low_cnt_q + 8'd1;
         rdy_d = HAS_GROUP && (model_dly != MODEL_NEVER_RDY) && !model_drop &&
                 (low_cnt_d >= model_dly);
      end
   end

   // Model registers.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         low_cnt_q <= '0;
         rdy_q     <= 1'b0;
      end else begin
         low_cnt_q <= low_cnt_d;
         rdy_q     <= rdy_d;
      end
   end

   assign rdy = rdy_q;

endmodule

// File: rtl/ddr2_idelay_ctrl_seq.sv
// IDELAYCTRL reset/lock sequencer: pulses the instance resets, waits for all
// synchronised RDYs, retries on timeout, and supervises lock afterwards.
module ddr2_idelay_ctrl_seq
   import ddr2_idelay_pkg::*;
#(
   parameter int unsigned NUM_CTRL     = 2,
   parameter string       IODELAY_GRP  = "IODELAY_MIG",
   parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY,
   parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
   localparam int unsigned RETRY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
   input  logic                  clk200,
   input  logic                  rst200_n,
   input  logic                  recal,
   input  logic [8*NUM_CTRL-1:0] model_rdy_dly,
   input  logic [NUM_CTRL-1:0]   model_rdy_drop,
   output logic                  idelay_ctrl_rdy,
   output logic [NUM_CTRL-1:0]   rdy_vec,
   output logic                  lost_lock,
   output logic                  ctrl_fail,
   output logic [RETRY_W-1:0]    retry_cnt
);

   localparam int unsigned TIMER_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

   ctrl_state_e          state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic                 ctrl_rst_q, ctrl_rst_d;
   logic                 lock_q, lock_d;
   logic                 fail_q, fail_d;
   logic                 lost_q, lost_d;
   logic [NUM_CTRL-1:0]  sync_q [SYNC_STAGES];
   logic [NUM_CTRL-1:0]  sync_d [SYNC_STAGES];
   logic [NUM_CTRL-1:0]  raw_rdy;
   logic                 all_rdy;

   for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
      ddr2_idelayctrl_cell #(
         .IODELAY_GRP (IODELAY_GRP)
      ) u_cell (
         .refclk     (clk200),
         .rst_n      (rst200_n),
         .rst        (ctrl_rst_q),
         .model_dly  (model_rdy_dly[8*g +: 8]),
         .model_drop (model_rdy_drop[g]),
         .rdy        (raw_rdy[g])
      );
   end

   assign all_rdy = &sync_q[SYNC_STAGES-1];

   // RDY synchroniser shift chain.
   always_comb begin
      sync_d[0] = raw_rdy;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   // Next-state, timer, retry and registered-output decode; recal overrides every state.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      timer_d = timer_q;
      if (timer_q != '1) timer_d = timer_q + TIMER_W'(1);
      lost_d  = (state_q == LOCKED) && !all_rdy;

      case (state_q)
         RST_HOLD: begin
            if (timer_q == TIMER_W'(RST_CYCLES - 1)) begin
               state_d = WAIT_RDY;
               timer_d = '0;
            end
         end
         WAIT_RDY: begin
            if (all_rdy) begin
               state_d = LOCKED;
               timer_d = '0;
            end else if (timer_q == TIMER_W'(LOCK_TIMEOUT - 1)) begin
               timer_d = '0;
               if (retry_q < RETRY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + RETRY_W'(1);
                  state_d = RST_HOLD;
               end else begin
                  state_d = FAILED;
               end
            end
         end
         LOCKED: begin
            if (!all_rdy) begin
               state_d = RST_HOLD;
               timer_d = '0;
               retry_d = '0;
            end
         end
         FAILED: ;
         default: begin
            state_d = RST_HOLD;
            timer_d = '0;
         end
      endcase

      if (recal) begin
         state_d = RST_HOLD;
         timer_d = '0;
         retry_d = '0;
      end

      ctrl_rst_d = (state_d == RST_HOLD) || (state_d == FAILED);
      lock_d     = (state_d == LOCKED);
      fail_d     = (state_d == FAILED);
   end

   // Sequencer state, counters, synchronisers and registered outputs.
   always_ff @(posedge clk200 or negedge rst200_n) begin
      if (!rst200_n) begin
         state_q    <= RST_HOLD;
         timer_q    <= '0;
         retry_q    <= '0;
         ctrl_rst_q <= 1'b1;
         lock_q     <= 1'b0;
         fail_q     <= 1'b0;
         lost_q     <= 1'b0;
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         retry_q    <= retry_d;
         ctrl_rst_q <= ctrl_rst_d;
         lock_q     <= lock_d;
         fail_q     <= fail_d;
         lost_q     <= lost_d;
         sync_q     <= sync_d;
      end
   end

   assign idelay_ctrl_rdy = lock_q;
   assign rdy_vec         = sync_q[SYNC_STAGES-1];
   assign lost_lock       = lost_q;
   assign ctrl_fail       = fail_q;
   assign retry_cnt       = retry_q;

endmodule

// File: tb/tb_ddr2_idelay_ctrl_seq.sv
// Self-checking bench: per-cycle comparison against a behavioural sequence model.
module tb_ddr2_idelay_ctrl_seq;

   localparam int NC = 2, RC = 16, LT = 64, MR = 2, SS = 2;
   localparam int P_HOLD = 0, P_WAIT = 1, P_LOCK = 2, P_FAIL = 3;

   logic           clk200 = 1'b0;
   logic           rst200_n = 1'b1;
   logic           recal = 1'b0;
   logic [8*NC-1:0] model_rdy_dly = {8'd9, 8'd5};
   logic [NC-1:0]  model_rdy_drop = '0;
   logic           idelay_ctrl_rdy;
   logic [NC-1:0]  rdy_vec;
   logic           lost_lock;
   logic           ctrl_fail;
   logic [1:0]     retry_cnt;

   ddr2_idelay_ctrl_seq #(
      .NUM_CTRL     (NC),
      .IODELAY_GRP  ("IODELAY_MIG"),
      .RST_CYCLES   (RC),
      .LOCK_TIMEOUT (LT),
      .MAX_RETRY    (MR),
      .SYNC_STAGES  (SS)
   ) dut (
      .clk200          (clk200),
      .rst200_n        (rst200_n),
      .recal           (recal),
      .model_rdy_dly   (model_rdy_dly),
      .model_rdy_drop  (model_rdy_drop),
      .idelay_ctrl_rdy (idelay_ctrl_rdy),
      .rdy_vec         (rdy_vec),
      .lost_lock       (lost_lock),
      .ctrl_fail       (ctrl_fail),
      .retry_cnt       (retry_cnt)
   );

   always #5 clk200 = ~clk200;

   int n_cmp = 0, n_bad = 0, cyc = 0;

   // behavioural model state
   int          m_phase, m_t, m_retry;
   bit          m_lost;
   int          m_low [NC];
   bit [NC-1:0] m_raw, m_vec;
   bit [NC-1:0] m_hist [$];

   // event trackers
   int first_lock, m_first_lock, first_rst_low, first_fail, first_r1, first_r2, lost_cnt;
   bit unlock_seen;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = P_HOLD; m_t = 0; m_retry = 0; m_lost = 1'b0;
      m_raw = '0; m_vec = '0;
      for (int i = 0; i < NC; i++) m_low[i] = 0;
      m_hist.delete();
      for (int i = 0; i < SS - 1; i++) m_hist.push_back('0);
   endtask

   // Advance the model by the clock edge that just passed, using the inputs held during it.
   task automatic model_step();
      bit          all_rdy, inst_rst;
      bit [NC-1:0] nraw;
      int          dly;
      if (!rst200_n) begin
         model_reset();
         return;
      end
      all_rdy  = (m_vec == '1);
      inst_rst = (m_phase == P_HOLD) || (m_phase == P_FAIL);
      nraw = '0;
      for (int i = 0; i < NC; i++) begin
         dly = int'(model_rdy_dly[8*i +: 8]);
         if (inst_rst) begin
            m_low[i] = 0;
         end else begin
            if (m_low[i] < 255) m_low[i] = m_low[i] + 1;
            nraw[i] = (dly != 255) && !model_rdy_drop[i] && (m_low[i] >= dly);
         end
      end
      m_hist.push_front(m_raw);
      m_vec = m_hist[SS-1];
      void'(m_hist.pop_back());
      m_raw  = nraw;
      m_lost = (m_phase == P_LOCK) && !all_rdy;
      if (recal) begin
         m_phase = P_HOLD; m_t = 0; m_retry = 0;
      end else begin
         case (m_phase)
            P_HOLD: if (m_t == RC - 1) begin m_phase = P_WAIT; m_t = 0; end
                    else m_t = m_t + 1;
            P_WAIT: if (all_rdy) begin m_phase = P_LOCK; m_t = 0; end
                    else if (m_t == LT - 1) begin
                       m_t = 0;
                       if (m_retry < MR) begin m_retry = m_retry + 1; m_phase = P_HOLD; end
                       else m_phase = P_FAIL;
                    end else m_t = m_t + 1;
            P_LOCK: if (!all_rdy) begin m_phase = P_HOLD; m_t = 0; m_retry = 0; end
            default: ;
         endcase
      end
   endtask

   task automatic check();
      chk("idelay_ctrl_rdy", int'(idelay_ctrl_rdy), int'(m_phase == P_LOCK));
      chk("ctrl_fail",       int'(ctrl_fail),       int'(m_phase == P_FAIL));
      chk("lost_lock",       int'(lost_lock),       int'(m_lost));
      chk("retry_cnt",       int'(retry_cnt),       m_retry);
      chk("rdy_vec",         int'(rdy_vec),         int'(m_vec));
      chk("inst_rst",        int'(dut.ctrl_rst_q),  int'(m_phase == P_HOLD || m_phase == P_FAIL));
   endtask

   task automatic clear_track();
      first_lock = -1; m_first_lock = -1; first_rst_low = -1; first_fail = -1;
      first_r1 = -1; first_r2 = -1; lost_cnt = 0; unlock_seen = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk200);
      model_step();
      cyc++;
      check();
      if (first_lock < 0 && idelay_ctrl_rdy) first_lock = cyc;
      if (m_first_lock < 0 && m_phase == P_LOCK) m_first_lock = cyc;
      if (first_rst_low < 0 && !dut.ctrl_rst_q) first_rst_low = cyc;
      if (first_fail < 0 && ctrl_fail) first_fail = cyc;
      if (first_r1 < 0 && retry_cnt == 2'd1) first_r1 = cyc;
      if (first_r2 < 0 && retry_cnt == 2'd2) first_r2 = cyc;
      if (lost_lock) lost_cnt++;
      if (!idelay_ctrl_rdy) unlock_seen = 1'b1;
   endtask

   task automatic wait_lock(input int limit);
      for (int k = 0; k < limit && !idelay_ctrl_rdy; k++) tick();
      chk("lock_within_budget", int'(idelay_ctrl_rdy), 1);
   endtask

   task automatic restart(input int d0, input int d1);
      #1 rst200_n = 1'b0;
      model_reset();
      repeat (3) tick();
      model_rdy_dly  = {8'(d1), 8'(d0)};
      model_rdy_drop = '0;
      rst200_n = 1'b1;
      cyc = 0;
      clear_track();
      check();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_track();
      model_reset();

      // Reset values, applied asynchronously.
      #1 rst200_n = 1'b0;
      #1;
      chk("rst_idelay_ctrl_rdy", int'(idelay_ctrl_rdy), 0);
      chk("rst_rdy_vec",         int'(rdy_vec), 0);
      chk("rst_ctrl_fail",       int'(ctrl_fail), 0);
      chk("rst_inst_rst",        int'(dut.ctrl_rst_q), 1);

      // Basic lock with delays 5 and 9.
      restart(5, 9);
      wait_lock(60);
      chk("lock_cycle",       first_lock, 28);
      chk("model_lock_cycle", m_first_lock, 28);
      chk("rst_low_cycle",    first_rst_low, 16);
      chk("retry_at_lock",    int'(retry_cnt), 0);

      // One-cycle RDY drop on instance 0 while locked.
      clear_track();
      model_rdy_drop = 2'b01;
      tick();
      model_rdy_drop = 2'b00;
      repeat (40) tick();
      chk("lost_lock_pulses", lost_cnt, 1);
      chk("unlock_seen",      int'(unlock_seen), 1);
      chk("relocked",         int'(idelay_ctrl_rdy), 1);

      // Instance 1 never ready: three attempts then FAILED.
      restart(5, 255);
      repeat (250) tick();
      chk("retry1_cycle", first_r1, 80);
      chk("retry2_cycle", first_r2, 160);
      chk("fail_cycle",   first_fail, 240);
      chk("fail_inst_rst", int'(dut.ctrl_rst_q), 1);

      // Recal out of FAILED with the model fixed.
      model_rdy_dly = {8'd9, 8'd5};
      recal = 1'b1;
      tick();
      recal = 1'b0;
      chk("fail_cleared", int'(ctrl_fail), 0);
      cyc = 0;
      clear_track();
      wait_lock(60);
      chk("recal_lock_cycle", first_lock, 28);
      chk("recal_retry",      int'(retry_cnt), 0);

      // recal coincident with all-ready in WAIT_RDY.
      restart(5, 9);
      repeat (27) tick();
      chk("coincide_vec", int'(rdy_vec), 3);
      recal = 1'b1;
      tick();
      recal = 1'b0;
      chk("coincide_no_lock", int'(idelay_ctrl_rdy), 0);
      chk("coincide_hold",    int'(dut.ctrl_rst_q), 1);
      cyc = 0;
      clear_track();
      wait_lock(60);
      chk("coincide_relock_cycle", first_lock, 28);

      // Async reset in the middle of the second WAIT_RDY attempt.
      restart(5, 255);
      repeat (110) tick();
      chk("mid_retry",   int'(retry_cnt), 1);
      chk("mid_rdy_vec", int'(rdy_vec), 1);
      #2 rst200_n = 1'b0;
      #1;
      chk("abort_retry",   int'(retry_cnt), 0);
      chk("abort_rdy_vec", int'(rdy_vec), 0);
      chk("abort_rdy",     int'(idelay_ctrl_rdy), 0);
      chk("abort_inst_rst", int'(dut.ctrl_rst_q), 1);
      model_reset();
      repeat (3) tick();
      model_rdy_dly = {8'd9, 8'd5};
      rst200_n = 1'b1;
      cyc = 0;
      clear_track();
      wait_lock(60);
      chk("abort_relock_cycle", first_lock, 28);
      chk("abort_rst_low",      first_rst_low, 16);

      // Randomised recal, drops and delay changes.
      restart(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)));
      for (int k = 0; k < 600; k++) begin
         recal = ($urandom_range(0, 149) == 0);
         model_rdy_drop = {($urandom_range(0, 79) == 0), ($urandom_range(0, 79) == 0)};
         if (k % 150 == 149) begin
            for (int i = 0; i < NC; i++)
               model_rdy_dly[8*i +: 8] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(1, 20));
         end
         tick();
      end
      recal = 1'b0;
      model_rdy_drop = '0;
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ddr2_idelay_ctrl_seq.md
DDR2_IDELAY_CTRL_SEQ -- requirements
Module: ddr2_idelay_ctrl_seq

Interface
REQ-001 Parameter NUM_CTRL, default 2: number of IDELAYCTRL instances (1..8).
REQ-002 Parameter IODELAY_GRP, default "IODELAY_MIG": IODELAY_GROUP attribute applied to every instance.
REQ-003 Parameter RST_CYCLES, default 16: IDELAYCTRL reset pulse length in clk200 cycles (>=10).
REQ-004 Parameter LOCK_TIMEOUT, default 4096: cycles allowed in WAIT_RDY per attempt.
REQ-005 Parameter MAX_RETRY, default 3: reset re-attempts before failure.
REQ-006 Parameter SYNC_STAGES, default 2: RDY synchroniser depth (>=2).
REQ-007 clk200  in  1  200 MHz reference and sequencer clock; the block's only clock.
REQ-008 rst200_n  in  1  asynchronous, active-low reset.
REQ-009 recal  in  1  single-cycle recalibration request.
REQ-010 idelay_ctrl_rdy  out  1  all instances locked.
REQ-011 rdy_vec  out  NUM_CTRL  synchronised per-instance RDY.
REQ-012 lost_lock  out  1  one-cycle pulse on loss of lock.
REQ-013 ctrl_fail  out  1  sticky retry-exhausted flag.
REQ-014 retry_cnt  out  clog2(MAX_RETRY+1)  attempts consumed in the current sequence.

Function
REQ-015 States: RST_HOLD, WAIT_RDY, LOCKED, FAILED; state and all outputs registered.
REQ-016 RST_HOLD: drive all instance RST high for exactly RST_CYCLES cycles, then go to WAIT_RDY with RST low.
REQ-017 WAIT_RDY: the timer counts from 0; all rdy_vec bits high -> LOCKED.
REQ-018 WAIT_RDY timeout (timer == LOCK_TIMEOUT-1, not all ready): if retry_cnt < MAX_RETRY, increment retry_cnt -> RST_HOLD; else -> FAILED.
REQ-019 LOCKED: idelay_ctrl_rdy = 1; any rdy_vec bit low -> lost_lock pulse for 1 cycle, retry_cnt cleared, -> RST_HOLD.
REQ-020 FAILED: ctrl_fail = 1, instance RST held high; exit only on recal.
REQ-021 recal in any state -> RST_HOLD, retry_cnt = 0, ctrl_fail = 0; a recal in the same cycle as all-ready in WAIT_RDY takes priority.
REQ-022 A RDY drop and recal in the same LOCKED cycle: lost_lock pulses, and recal semantics apply.
REQ-023 idelay_ctrl_rdy = 1 iff state == LOCKED; it rises SYNC_STAGES+1 cycles after the last raw RDY rises.
REQ-024 Each raw RDY passes through SYNC_STAGES flops before use.
REQ-025 Counters saturate and never wrap; the timer clears on every state entry.

Reset
REQ-026 While rst200_n is low: state = RST_HOLD, counters = 0, synchronisers = 0, instance RST = 1, all outputs = 0.
REQ-027 After rst200_n deasserts, the sequence starts at RST_HOLD cycle 0.
REQ-028 Assertion of rst200_n mid-sequence (any state) aborts immediately with the REQ-026 values.

Structure
REQ-029 Package ddr2_idelay_pkg holds the state encoding and the default constants (RST_CYCLES, LOCK_TIMEOUT, MAX_RETRY, SYNC_STAGES).
REQ-030 Sub-module ddr2_idelayctrl_cell wraps one IDELAYCTRL carrying the IODELAY_GROUP attribute; it is instantiated NUM_CTRL times by a generate loop.
REQ-031 Simulation uses a behavioural IDELAYCTRL model with a per-instance programmable RDY delay and a forced-drop control.

Verification (NUM_CTRL=2, RST_CYCLES=16, LOCK_TIMEOUT=64, MAX_RETRY=2, SYNC_STAGES=2)
REQ-032 Release reset; model RDY delays 5 and 9 cycles -> RST high for 16 cycles; idelay_ctrl_rdy rises 3 cycles after instance 1 RDY; retry_cnt = 0.
REQ-033 Instance 1 never ready -> three 64-cycle attempts with retry_cnt 1 then 2; FAILED entered with ctrl_fail = 1 and RST held high.
REQ-034 From FAILED, pulse recal with the model fixed -> ctrl_fail clears the next cycle; a fresh 16-cycle RST follows and the block locks with retry_cnt = 0.
REQ-035 In LOCKED, force instance 0 RDY low for 1 cycle -> one lost_lock pulse, idelay_ctrl_rdy drops, the block relocks.
REQ-036 recal in the same cycle as all-ready in WAIT_RDY -> RST_HOLD is entered and LOCKED is not entered.
REQ-037 Assert rst200_n mid-WAIT_RDY -> all outputs 0 asynchronously; the sequence restarts at RST_HOLD cycle 0 after release.
